// File: rtl/byte_word_packer_pkg.sv
// Shared constants, lane/handshake macros and the word-assembly helper for the
// byte-to-64-bit-word ingress packer.
`ifndef BYTE_WORD_PACKER_MACROS
`define BYTE_WORD_PACKER_MACROS
`define BWP_XFER(v, r) ((v) && (r))
`define BWP_LANE(i) (8*(i)) +: 8
`endif

package byte_word_packer_pkg;

  localparam int WORD_W = 64;
  localparam int BYTE_W = 8;
  localparam int LANES  = WORD_W / BYTE_W;

  // Lanes below cnt come from the accumulator, lane cnt takes the new byte,
  // everything above is forced to zero.
  function automatic logic [WORD_W-1:0] lane_merge(input logic [55:0] acc,
                                                   input logic [2:0]  cnt,
                                                   input logic [7:0]  b);
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] w;
    a = {8'h00, acc};
    w = '0;
    for (int i = 0; i < LANES; i++) begin
      if (i < int'(cnt)) begin
        w[`BWP_LANE(i)] = a[`BWP_LANE(i)];
      end else if (i == int'(cnt)) begin
        w[`BWP_LANE(i)] = b;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs an isReady/canReceive byte stream little-endian into 64-bit words,
// with last-byte flush of partial (zero-padded) words and a byte count per word.
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_byte,
  input  logic             in_last,
  input  logic             in_isReady,
  output logic             in_canReceive,
  output logic [63:0]      out,
  output logic [3:0]       out_bytes,
  output logic             out_last,
  output logic             out_isReady,
  input  logic             out_canReceive,
  output logic [CNT_W-1:0] msg_bytes
);

  logic [55:0]      acc, acc_nxt;
  logic [2:0]       acc_cnt, acc_cnt_nxt;
  logic             flush_pending, flush_pending_nxt;
  logic [63:0]      out_nxt;
  logic [3:0]       out_bytes_nxt;
  logic             out_last_nxt, out_valid_nxt;
  logic [CNT_W-1:0] msg_bytes_nxt;
  logic [63:0]      acc_wide;

  logic in_xfer, drain, out_free, complete;

  // Handshake: a transfer happens on a rising edge where both isReady and
  // canReceive are high; isReady never waits on canReceive.
  assign in_canReceive = ~rst & ~flush_pending & (~out_isReady | (acc_cnt != 3'd7));
  assign in_xfer       = `BWP_XFER(in_isReady, in_canReceive);
  assign drain         = `BWP_XFER(out_isReady, out_canReceive);
  assign out_free      = ~out_isReady | drain;
  assign complete      = in_xfer & (in_last | (acc_cnt == 3'd7));

  always_comb begin
    acc_nxt           = acc;
    acc_cnt_nxt       = acc_cnt;
    flush_pending_nxt = flush_pending;
    msg_bytes_nxt     = msg_bytes;
    out_nxt           = out;
    out_bytes_nxt     = out_bytes;
    out_last_nxt      = out_last;
    out_valid_nxt     = out_isReady;
    acc_wide          = {8'h00, acc};

    // A drained register empties to zeros unless something reloads it below.
    if (drain) begin
      out_valid_nxt = 1'b0;
      out_nxt       = '0;
      out_bytes_nxt = '0;
      out_last_nxt  = 1'b0;
    end

    if (flush_pending && drain) begin
      // acc upper lanes are always zero, so the held partial word is already padded.
      out_nxt           = {8'h00, acc};
      out_bytes_nxt     = {1'b0, acc_cnt};
      out_last_nxt      = 1'b1;
      out_valid_nxt     = 1'b1;
      acc_nxt           = '0;
      acc_cnt_nxt       = '0;
      flush_pending_nxt = 1'b0;
      msg_bytes_nxt     = '0;
    end else if (complete && out_free) begin
      out_nxt       = lane_merge(acc, acc_cnt, in_byte);
      out_bytes_nxt = {1'b0, acc_cnt} + 4'd1;
      out_last_nxt  = in_last;
      out_valid_nxt = 1'b1;
      acc_nxt       = '0;
      acc_cnt_nxt   = '0;
      msg_bytes_nxt = in_last ? '0 : msg_bytes + 1'b1;
    end else if (in_xfer) begin
      // Either a mid-word byte, or a last byte parked until the register frees.
      acc_wide[`BWP_LANE(acc_cnt)] = in_byte;
      acc_nxt       = acc_wide[55:0];
      acc_cnt_nxt   = acc_cnt + 3'd1;
      msg_bytes_nxt = msg_bytes + 1'b1;
      if (in_last) begin
        flush_pending_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc           <= '0;
      acc_cnt       <= '0;
      flush_pending <= 1'b0;
      msg_bytes     <= '0;
      out           <= '0;
      out_bytes     <= '0;
      out_last      <= 1'b0;
      out_isReady   <= 1'b0;
    end else begin
      acc           <= acc_nxt;
      acc_cnt       <= acc_cnt_nxt;
      flush_pending <= flush_pending_nxt;
      msg_bytes     <= msg_bytes_nxt;
      out           <= out_nxt;
      out_bytes     <= out_bytes_nxt;
      out_last      <= out_last_nxt;
      out_isReady   <= out_valid_nxt;
    end
  end

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed bench for byte_word_packer: packing, last/flush, backpressure,
// async reset and a long streaming message checked against a scoreboard.
module tb_byte_word_packer;

  localparam int CNT_W = 16;
  localparam int STREAM_BYTES = 10752;
  localparam int STREAM_WORDS = 1344;

  logic             clk = 1'b0;
  logic             rst;
  logic [7:0]       in_byte;
  logic             in_last;
  logic             in_isReady;
  logic             in_canReceive;
  logic [63:0]      out;
  logic [3:0]       out_bytes;
  logic             out_last;
  logic             out_isReady;
  logic             out_canReceive;
  logic [CNT_W-1:0] msg_bytes;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_q[$];
  logic        mon_en = 1'b0;
  int          words_seen = 0;
  int          lasts_seen = 0;

  byte_word_packer #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .in_byte        (in_byte),
    .in_last        (in_last),
    .in_isReady     (in_isReady),
    .in_canReceive  (in_canReceive),
    .out            (out),
    .out_bytes      (out_bytes),
    .out_last       (out_last),
    .out_isReady    (out_isReady),
    .out_canReceive (out_canReceive),
    .msg_bytes      (msg_bytes)
  );

  always #5 clk = ~clk;

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs == exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one byte and returns once it has transferred; stalls counts wait cycles.
  task automatic send_byte(input logic [7:0] b, input logic l, output int stalls);
    stalls = 0;
    in_byte    = b;
    in_last    = l;
    in_isReady = 1'b1;
    @(negedge clk);
    while (!in_canReceive && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      checks++;
      errors++;
      $error("FAIL send_timeout: observed in_canReceive low for %0d cycles expected transfer", stalls);
    end
    @(posedge clk);
    #1;
    in_isReady = 1'b0;
    in_last    = 1'b0;
  endtask

  // Scoreboard for the streaming message.
  always @(negedge clk) begin
    if (mon_en && out_isReady && out_canReceive) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL stream_extra: observed word %h expected none", out);
      end else begin
        chk64("stream_word", out, exp_q.pop_front());
        chk1("stream_last", out_last, words_seen == STREAM_WORDS - 1);
        chk_int("stream_bytes", int'(out_bytes), 8);
      end
      words_seen++;
      if (out_last) lasts_seen++;
    end
  end

  initial begin
    int st;
    int total_stalls;
    logic [63:0] w;

    rst            = 1'b1;
    in_byte        = 8'h00;
    in_last        = 1'b0;
    in_isReady     = 1'b0;
    out_canReceive = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_canReceive", in_canReceive, 1'b0);
    chk1("rst_out_isReady", out_isReady, 1'b0);
    chk64("rst_out", out, 64'h0);
    chk_int("rst_msg_bytes", int'(msg_bytes), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk1("post_rst_in_canReceive", in_canReceive, 1'b1);
    @(posedge clk);
    #1;

    // Full word 0x01..0x08, sink ready
    total_stalls = 0;
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b0, st);
      total_stalls += st;
    end
    chk_int("t1_no_stall", total_stalls, 0);
    chk1("t1_valid", out_isReady, 1'b1);
    chk64("t1_word", out, 64'h0807060504030201);
    chk_int("t1_bytes", int'(out_bytes), 8);
    chk1("t1_last", out_last, 1'b0);
    chk_int("t1_msg", int'(msg_bytes), 8);
    @(posedge clk);
    #1;
    chk1("t1_drained", out_isReady, 1'b0);
    chk64("t1_out_zero", out, 64'h0);

    // Short message AA BB CC with last
    send_byte(8'hAA, 1'b0, st);
    send_byte(8'hBB, 1'b0, st);
    chk_int("t2_msg_mid", int'(msg_bytes), 10);
    send_byte(8'hCC, 1'b1, st);
    chk64("t2_word", out, 64'h0000000000CCBBAA);
    chk_int("t2_bytes", int'(out_bytes), 3);
    chk1("t2_last", out_last, 1'b1);
    chk_int("t2_msg_zero", int'(msg_bytes), 0);
    @(posedge clk);
    #1;

    // Backpressure: 16 bytes with sink stalled
    out_canReceive = 1'b0;
    for (int i = 0; i < 15; i++) send_byte(8'(8'h10 + i), 1'b0, st);
    in_byte    = 8'h1F;
    in_isReady = 1'b1;
    @(negedge clk);
    chk1("t3_stall_after_15", in_canReceive, 1'b0);
    chk64("t3_hold_a", out, 64'h1716151413121110);
    @(posedge clk);
    #1;
    chk64("t3_hold_a2", out, 64'h1716151413121110);
    out_canReceive = 1'b1;
    @(negedge clk);
    chk1("t3_a_valid", out_isReady, 1'b1);
    chk64("t3_a_word", out, 64'h1716151413121110);
    @(posedge clk);
    #1;
    chk1("t3_a_drained", out_isReady, 1'b0);
    @(negedge clk);
    chk1("t3_resume", in_canReceive, 1'b1);
    @(posedge clk);
    #1;
    in_isReady     = 1'b0;
    out_canReceive = 1'b0;
    chk64("t3_b_word", out, 64'h1F1E1D1C1B1A1918);
    chk_int("t3_b_bytes", int'(out_bytes), 8);
    chk_int("t3_msg", int'(msg_bytes), 16);

    // Last byte while the register is occupied: flush_pending path
    send_byte(8'h55, 1'b0, st);
    send_byte(8'h66, 1'b1, st);
    chk1("t4_flush_pending", dut.flush_pending, 1'b1);
    chk_int("t4_msg", int'(msg_bytes), 18);
    chk64("t4_hold_b", out, 64'h1F1E1D1C1B1A1918);
    @(negedge clk);
    chk1("t4_in_blocked", in_canReceive, 1'b0);
    @(posedge clk);
    #1 out_canReceive = 1'b1;
    @(posedge clk);
    #1;
    chk1("t4_valid", out_isReady, 1'b1);
    chk64("t4_word", out, 64'h0000000000006655);
    chk_int("t4_bytes", int'(out_bytes), 2);
    chk1("t4_last", out_last, 1'b1);
    chk_int("t4_msg_zero", int'(msg_bytes), 0);
    chk1("t4_flush_clear", dut.flush_pending, 1'b0);
    @(posedge clk);
    #1;

    // Async reset mid-message with a word held
    out_canReceive = 1'b0;
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC0 + i), 1'b0, st);
    for (int i = 0; i < 5; i++) send_byte(8'(8'hE1 + i), 1'b0, st);
    chk_int("t5_msg_pre", int'(msg_bytes), 13);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk1("t5_rst_valid", out_isReady, 1'b0);
    chk64("t5_rst_out", out, 64'h0);
    chk_int("t5_rst_bytes", int'(out_bytes), 0);
    chk1("t5_rst_last", out_last, 1'b0);
    chk_int("t5_rst_msg", int'(msg_bytes), 0);
    chk1("t5_rst_in_canReceive", in_canReceive, 1'b0);
    @(posedge clk);
    #1;
    rst            = 1'b0;
    out_canReceive = 1'b1;
    for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), 1'b0, st);
    chk64("t5_clean_word", out, 64'h3837363534333231);
    chk_int("t5_clean_msg", int'(msg_bytes), 8);
    @(posedge clk);
    #1;

    // Long streaming message, sink always ready
    mon_en       = 1'b1;
    total_stalls = 0;
    w            = '0;
    for (int i = 0; i < STREAM_BYTES; i++) begin
      w[8*(i%8) +: 8] = 8'(i);
      if (i % 8 == 7) begin
        exp_q.push_back(w);
        w = '0;
      end
      send_byte(8'(i), i == STREAM_BYTES - 1, st);
      total_stalls += st;
    end
    repeat (4) @(posedge clk);
    #1;
    mon_en = 1'b0;
    chk_int("t6_words", words_seen, STREAM_WORDS);
    chk_int("t6_lasts", lasts_seen, 1);
    chk_int("t6_stalls", total_stalls, 0);
    chk_int("t6_queue_empty", exp_q.size(), 0);
    chk_int("t6_msg_zero", int'(msg_bytes), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/byte_word_packer.md
Name: byte_word_packer

Overview:
- Host-side ingress stage that sits directly upstream of the KEM core's 64-bit `in` port.
- Accepts a byte stream with an `isReady`/`canReceive` handshake and packs it little-endian into 64-bit words: first byte goes to bits [7:0], eighth byte to bits [63:56].
- Presents each word on the same handshake the core consumes.
- Supports a `last` marker that flushes a partial word, zero-padded, and reports the valid byte count of each word.

Parameters:
- CNT_W, 16, width of the per-message byte counter; wraps modulo 2^CNT_W.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_byte  in  8  input data byte.
- in_last  in  1  qualifies in_byte as final byte of the message.
- in_isReady  in  1  source offers in_byte.
- in_canReceive  out  1  packer can accept a byte this cycle.
- out  out  64  packed word, little-endian byte order.
- out_bytes  out  4  number of valid bytes in out, 1..8.
- out_last  out  1  word is the final word of the message.
- out_isReady  out  1  out holds a valid word.
- out_canReceive  in  1  sink accepts the word this cycle.
- msg_bytes  out  CNT_W  bytes accepted in the current message.

Behaviour:
- Transfer rule:
  - Input transfer when in_isReady && in_canReceive at the rising edge.
  - Output transfer when out_isReady && out_canReceive at the rising edge.
- State:
  - acc[55:0] accumulator, acc_cnt[2:0] = bytes held (0..7).
  - Output register out/out_bytes/out_last with valid flag.
  - flush_pending flag.
- Reset (async, immediate):
  - acc=0, acc_cnt=0, flush_pending=0, msg_bytes=0.
  - out_isReady=0, out=0, out_bytes=0, out_last=0.
  - in_canReceive=0 while rst is high; it becomes 1 in the first cycle after release.
- in_canReceive = ~rst && ~flush_pending && (~out_isReady || acc_cnt != 7).
  - Registered terms only; no combinational path from out_canReceive.
- Accepted byte, not completing a word (acc_cnt<7 and ~in_last):
  - Byte written at acc[8*acc_cnt +: 8].
  - acc_cnt++.
  - msg_bytes++.
- Word completion, on acc_cnt==7 byte accepted, or in_last byte accepted:
  - Word = {byte, acc} aligned at its lane, unused upper lanes forced to 0.
  - out_bytes = acc_cnt+1, out_last = in_last.
  - The word loads the output register next edge if the register is free or drains the same edge; otherwise see flush_pending.
  - acc and acc_cnt cleared.
  - msg_bytes cleared if in_last, else incremented.
- Last byte while output register is occupied and not draining (only possible with acc_cnt<7):
  - Byte stored in acc, acc_cnt++, flush_pending=1.
  - While pending, in_canReceive=0.
  - The edge the output register drains, the pending partial word loads with out_last=1 and out_bytes=acc_cnt.
  - Then acc, acc_cnt and flush_pending clear and msg_bytes=0.
- Output register:
  - Holds data stable while out_isReady && ~out_canReceive.
  - Clears its valid flag on drain unless reloaded the same edge.
  - Back-to-back load and drain sustains 1 byte/cycle input throughput.
- Latency: the word completed by an accepted byte at edge t has out_isReady=1 after edge t.
- Boundaries:
  - in_last with acc_cnt==7 produces a full word with out_last=1.
  - No empty words: in_last always carries a byte, so a zero-length message is impossible.
  - msg_bytes wraps silently at 2^CNT_W.
  - out is 0 whenever out_isReady=0.
- Reset mid-message discards the accumulator and the output word with no partial emission.

Decomposition:
- Shared package / include:
  - Word width 64, byte width 8.
  - Byte-lane indexing macro.
  - The handshake transfer macro already used by the core interfaces.
- No sub-module needed.
- Optional reuse: the output register can be the codebase's existing one-entry `isReady`/`canReceive` holding register, named word_hold_reg, if present.

Test Plan:
- Bytes 0x01..0x08 streamed, out_canReceive=1 -> one word out=0x0807060504030201, out_bytes=8, out_last=0, in_canReceive never drops.
- 3 bytes 0xAA,0xBB,0xCC with last on 0xCC -> out=0x0000000000CCBBAA, out_bytes=3, out_last=1, msg_bytes returns to 0.
- 16 bytes with out_canReceive=0 throughout -> first word held stable, in_canReceive drops after 15 bytes accepted; raising out_canReceive drains both words in order with no loss.
- Word A pending in the output register, then 2-byte message with last -> flush_pending=1 and in_canReceive=0 until A drains; next word out_bytes=2, out_last=1.
- rst pulsed after 5 bytes -> outputs and msg_bytes zero immediately; next 8 bytes form a clean word with no stale data.
- Continuous 1344-word message (10752 bytes, last on final byte), sink always ready -> exactly 1344 words, only the final one with out_last=1, zero input stalls.
